addsub_result_stage: RTL
========================

Name: addsub_result_stage

Overview:
- Downstream stage of binary_adder_subtractor; consumes its combinational sum/cout, plus the operand sign bits and the mode bit (cin).
- Computes N/Z/C/V flags for each result and buffers result+flags in a 2-entry valid/ready queue toward the consumer.
- Keeps a saturating count of signed-overflow results for debug readout.

Parameters:
WIDTH, 4, data width of sum (matches adder-subtractor operand width)
CNT_W, 8, width of overflow event counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream presents a result this cycle
in_ready  output  1  stage can accept (queue not full)
sum  input  WIDTH  sum from adder-subtractor
cout  input  1  carry out from adder-subtractor
sub  input  1  mode (same signal as adder cin): 0 add, 1 subtract
a_msb  input  1  MSB of operand a
b_msb  input  1  MSB of operand b (uninverted)
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_sum  output  WIDTH  head result
out_flags  output  4  head flags {N,Z,C,V}
ovf_count  output  CNT_W  saturating count of accepted results with V=1
ovf_clr  input  1  synchronous clear of ovf_count

Behaviour:
- Reset (async, rst=1): queue emptied, count=0, out_valid=0, out_sum=0, out_flags=0, ovf_count=0; in_ready=1 as soon as rst deasserts. Entries in flight at reset are dropped.
- Flags are computed combinationally from inputs and stored with the entry:
  - N = sum[WIDTH-1]
  - Z = (sum == 0)
  - C = cout XOR sub. Add: 1 = carry out. Sub: 1 = borrow, i.e. a < b unsigned.
  - V = (a_msb == (b_msb XOR sub)) AND (sum[WIDTH-1] != a_msb). This is two's-complement overflow.
- Queue: 2 entries, FIFO order; count in {0,1,2}.
  - in_ready = (count < 2). It must not depend on out_ready; there is no combinational path in->out.
  - out_valid = (count != 0).
  - out_sum/out_flags come from the head entry register; latency is 1 cycle from accept to out_valid.
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- Simultaneous push and pop:
  - count=1: count stays 1; head becomes the new entry next cycle.
  - count=2: push impossible (in_ready=0); pop only.
  - count=0: push only; the new entry appears as head next cycle.
- Stall: while out_valid && !out_ready, out_sum and out_flags must hold stable.
- Empty queue: out_sum/out_flags hold their last value. The consumer must ignore them when out_valid=0.
- ovf_count:
  - +1 on each accepted push with V=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - ovf_clr has priority over a same-cycle increment: the result is 0.
- sum/cout/sub/a_msb/b_msb are sampled only on an accepted push. They are don't-care otherwise.

Test Plan:
- Reset then push sum=0100,cout=1,sub=0,a_msb=1,b_msb=1 (10+10), out_ready=1 -> next cycle out_valid=1, out_sum=0100, flags N0 Z0 C1 V1; ovf_count=1.
- Push 1010-1010: sum=0000,cout=1,sub=1,a_msb=1,b_msb=1 -> flags N0 Z1 C0 V0. Push 6+3: sum=1001,cout=0,sub=0,a_msb=0,b_msb=0 -> N1 Z0 C0 V1. Push 6-3: sum=0011,cout=1,sub=1,a_msb=0,b_msb=0 -> all flags 0.
- out_ready=0, push 3 results back-to-back -> first two accepted, in_ready=0 on cycle 3, third held. Raise out_ready -> outputs drain in order with no loss or duplication; out_sum is stable while stalled.
- count=1, push and pop in the same cycle for 5 consecutive cycles -> count stays 1, out_valid continuous, each result emitted exactly once, 1-cycle latency.
- CNT_W=2: push 5 overflow results -> ovf_count saturates at 3. Assert ovf_clr together with another V=1 push -> ovf_count=0.
- Assert rst mid-stream with count=2 -> out_valid=0, ovf_count=0 immediately (async). After release, in_ready=1 and the next push is the only entry output.

Source files
------------

// File: rtl/addsub_result_stage.sv
// Result stage behind the adder-subtractor: derives N/Z/C/V for each result and
// buffers result+flags in a 2-entry valid/ready queue, with a saturating overflow count.
module addsub_result_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             sub,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;  // {N,Z,C,V}
  } entry_t;

  entry_t     head, tail, new_e;
  logic [1:0] count;
  logic       push, pop, v_new;

  // C is normalised so that in subtract mode it reads as borrow (a < b unsigned).
  always_comb begin
    v_new     = (a_msb == (b_msb ^ sub)) && (sum[WIDTH-1] != a_msb);
    new_e.sum = sum;
    new_e.flags = {sum[WIDTH-1], (sum == '0), cout ^ sub, v_new};
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_sum   = head.sum;
  assign out_flags = head.flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // Head is a real register so the output never sees the input combinationally;
      // on empty it simply keeps its last contents.
      if (push && (count == 2'd0 || (count == 2'd1 && pop)))
        head <= new_e;
      else if (pop && count == 2'd2)
        head <= tail;
      if (push && count == 2'd1 && !pop)
        tail <= new_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_count <= '0;
    else if (ovf_clr)
      ovf_count <= '0;
    else if (push && v_new && !(&ovf_count))
      ovf_count <= ovf_count + 1'b1;
  end

endmodule
